// File: rtl/aes_result_sequencer.sv
// aes_result_sequencer
// Captures one 128-bit cipher result through a valid/ready handshake and
// presents it one byte per dwell period (byte 0 = block_in[0:7] first) so the
// BCD encoder and seven-segment drivers can show all 16 bytes. A match flag
// records whether the captured block equalled the expected block.
//
// Optional build macro: AES_SEQ_AUTO_REPEAT_EN
//   undefined : single pass over the 16 bytes, then park in DONE showing byte 15.
//   defined   : the block repeats forever (DONE is never entered) and a new
//               block may be accepted while bytes are being shown.
module aes_result_sequencer #(
  parameter int DWELL_CYCLES = 25000000,
  parameter int CNT_W        = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] block_in,
  input  logic [0:127] expected_in,
  input  logic         hold,
  output logic [7:0]   byte_out,
  output logic [3:0]   byte_idx,
  output logic         byte_valid,
  output logic         done,
  output logic         match_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last counter value of a dwell period; the counter never goes past it.
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       IDX_LAST   = 4'd15;

  // Byte k of a block is bits [8k:8k+7]; bit 8k lands on the MSB of the byte.
  function automatic logic [7:0] byteOf(input logic [0:127] blk, input logic [3:0] idx);
    byteOf = blk[{idx, 3'b000} +: 8];
  endfunction

  state_t           state_r;
  state_t           stateNext_s;
  logic [0:127]     blk_r;
  logic [0:127]     blkNext_s;
  logic [CNT_W-1:0] dwellCnt_r;
  logic [CNT_W-1:0] dwellCntNext_s;
  logic [3:0]       byteIdx_r;
  logic [3:0]       byteIdxNext_s;
  logic [7:0]       byteOut_r;
  logic [7:0]       byteOutNext_s;
  logic             byteValid_r;
  logic             byteValidNext_s;
  logic             done_r;
  logic             doneNext_s;
  logic             match_r;
  logic             matchNext_s;
  logic             ready_s;
  logic             accept_s;

  // Handshake readiness: free in IDLE/DONE; during SHOW only when repeating is enabled.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      IDLE:    ready_s = 1'b1;
      DONE:    ready_s = 1'b1;
`ifdef AES_SEQ_AUTO_REPEAT_EN
      SHOW:    ready_s = 1'b1;
`else
      SHOW:    ready_s = 1'b0;
`endif
      default: ready_s = 1'b0;
    endcase
  end

  assign accept_s = in_valid & ready_s;
  assign in_ready = ready_s;

  // Next-state and next-datapath decode; acceptance wins over hold and dwell stepping.
  always_comb begin
    stateNext_s     = state_r;
    blkNext_s       = blk_r;
    dwellCntNext_s  = dwellCnt_r;
    byteIdxNext_s   = byteIdx_r;
    byteOutNext_s   = byteOut_r;
    byteValidNext_s = byteValid_r;
    doneNext_s      = 1'b0;
    matchNext_s     = match_r;

    if (accept_s) begin
      // A fresh block always restarts at byte 0 with a cleared dwell counter.
      blkNext_s       = block_in;
      matchNext_s     = (block_in == expected_in);
      byteIdxNext_s   = 4'd0;
      byteOutNext_s   = byteOf(block_in, 4'd0);
      byteValidNext_s = 1'b1;
      dwellCntNext_s  = CNT_ZERO;
      stateNext_s     = SHOW;
    end else begin
      case (state_r)
        IDLE: begin
          stateNext_s = IDLE;
        end
        DONE: begin
          // Byte 15 and its index stay on the display until a new block arrives.
          stateNext_s = DONE;
        end
        SHOW: begin
          if (hold) begin
            dwellCntNext_s = dwellCnt_r;
          end else if (dwellCnt_r != DWELL_LAST) begin
            dwellCntNext_s = dwellCnt_r + CNT_ONE;
          end else if (byteIdx_r != IDX_LAST) begin
            dwellCntNext_s = CNT_ZERO;
            byteIdxNext_s  = byteIdx_r + 4'd1;
            byteOutNext_s  = byteOf(blk_r, byteIdx_r + 4'd1);
          end else begin
            doneNext_s = 1'b1;
`ifdef AES_SEQ_AUTO_REPEAT_EN
            // Wrap straight back to byte 0 of the same block.
            dwellCntNext_s  = CNT_ZERO;
            byteIdxNext_s   = 4'd0;
            byteOutNext_s   = byteOf(blk_r, 4'd0);
            byteValidNext_s = 1'b1;
            stateNext_s     = SHOW;
`else
            byteValidNext_s = 1'b0;
            stateNext_s     = DONE;
`endif
          end
        end
        default: begin
          stateNext_s = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_r       <= 128'd0;
      dwellCnt_r  <= CNT_ZERO;
      byteIdx_r   <= 4'd0;
      byteOut_r   <= 8'h00;
      byteValid_r <= 1'b0;
      done_r      <= 1'b0;
      match_r     <= 1'b0;
    end else begin
      blk_r       <= blkNext_s;
      dwellCnt_r  <= dwellCntNext_s;
      byteIdx_r   <= byteIdxNext_s;
      byteOut_r   <= byteOutNext_s;
      byteValid_r <= byteValidNext_s;
      done_r      <= doneNext_s;
      match_r     <= matchNext_s;
    end
  end

  assign byte_out   = byteOut_r;
  assign byte_idx   = byteIdx_r;
  assign byte_valid = byteValid_r;
  assign done       = done_r;
  assign match_flag = match_r;

endmodule

// File: tb/tb_aes_result_sequencer.sv
// tb_aes_result_sequencer
// Two sequencers run side by side: instance 0 with a dwell of 4 cycles and
// instance 1 with a dwell of 1 cycle. A reference model tracks, per instance,
// only the captured block and the number of un-held cycles since acceptance;
// the shown byte is that count divided by the dwell. Directed literal checks
// pin the model to hand-computed byte values and timings.
// Honours AES_SEQ_AUTO_REPEAT_EN the same way the design does.
module tb_aes_result_sequencer;

  logic         clk;
  logic         rst [2];
  logic         vld [2];
  logic         hld [2];
  logic [127:0] blk [2];
  logic [127:0] exb [2];
  logic         rdy [2];
  logic [7:0]   bo  [2];
  logic [3:0]   bi  [2];
  logic         bv  [2];
  logic         dn  [2];
  logic         mf  [2];

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  localparam logic [127:0] BLK_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;

  aes_result_sequencer #(.DWELL_CYCLES(4), .CNT_W(3)) dut0 (
    .clk(clk), .reset(rst[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .block_in(blk[0]), .expected_in(exb[0]), .hold(hld[0]),
    .byte_out(bo[0]), .byte_idx(bi[0]), .byte_valid(bv[0]),
    .done(dn[0]), .match_flag(mf[0])
  );

  aes_result_sequencer #(.DWELL_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .reset(rst[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .block_in(blk[1]), .expected_in(exb[1]), .hold(hld[1]),
    .byte_out(bo[1]), .byte_idx(bi[1]), .byte_valid(bv[1]),
    .done(dn[1]), .match_flag(mf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = nothing captured, 1 = presenting, 2 = finished
  int           mMode  [2];
  int           mT     [2];
  logic [127:0] mBlk   [2];
  bit           mMatch [2];
  bit           mDone  [2];

  function automatic int dwOf(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic bit modelReady(input int i);
`ifdef AES_SEQ_AUTO_REPEAT_EN
    return 1'b1;
`else
    return (mMode[i] != 1);
`endif
  endfunction

  function automatic logic [7:0] mByte(input int i, input int k);
    return mBlk[i][127 - 8*k -: 8];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        mMode[i] = 0; mT[i] = 0; mBlk[i] = 128'd0; mMatch[i] = 1'b0; mDone[i] = 1'b0;
      end else begin
        mDone[i] = 1'b0;
        if (vld[i] && modelReady(i)) begin
          mBlk[i] = blk[i]; mMatch[i] = (blk[i] == exb[i]); mT[i] = 0; mMode[i] = 1;
        end else if (mMode[i] == 1 && !hld[i]) begin
          mT[i]++;
          if (mT[i] == 16 * dwOf(i)) begin
            mDone[i] = 1'b1;
`ifdef AES_SEQ_AUTO_REPEAT_EN
            mT[i] = 0;
`else
            mMode[i] = 2;
`endif
          end
        end
      end
    end
  end

  // Compare every DUT output with the model once per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] eb;
        logic [3:0] ei;
        logic       ev;
        eb = 8'h00; ei = 4'd0; ev = 1'b0;
        if (mMode[i] == 1) begin
          ei = 4'(mT[i] / dwOf(i)); eb = mByte(i, mT[i] / dwOf(i)); ev = 1'b1;
        end else if (mMode[i] == 2) begin
          ei = 4'd15; eb = mByte(i, 15); ev = 1'b0;
        end
        check($sformatf("m%0d_byte_out", i), 32'(bo[i]), 32'(eb));
        check($sformatf("m%0d_byte_idx", i), 32'(bi[i]), 32'(ei));
        check($sformatf("m%0d_byte_valid", i), 32'(bv[i]), 32'(ev));
        check($sformatf("m%0d_done", i), 32'(dn[i]), 32'(mDone[i]));
        check($sformatf("m%0d_match", i), 32'(mf[i]), 32'(mMatch[i]));
        check($sformatf("m%0d_in_ready", i), 32'(rdy[i]), 32'(modelReady(i)));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] aBytes [16] = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                              8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};

  initial begin
    int cnt;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; vld[i] = 1'b1; hld[i] = 1'b0; blk[i] = BLK_A; exb[i] = BLK_A;
    end

    // Reset held 3 cycles with in_valid high.
    tick();
    started = 1'b1;
    tick();
    tick();
    check("rst_byte_valid", 32'(bv[0]), 32'd0);
    check("rst_match", 32'(mf[0]), 32'd0);
    check("rst_byte_out", 32'(bo[0]), 32'h00);
    for (int i = 0; i < 2; i++) begin rst[i] = 1'b0; vld[i] = 1'b0; end
    #1;
    check("rst_in_ready", 32'(rdy[0]), 32'd1);

    // Single pass, dwell 4.
    blk[0] = BLK_A; exb[0] = BLK_A; vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    check("a_byte0", 32'(bo[0]), 32'h69);
    check("a_idx0", 32'(bi[0]), 32'd0);
    check("a_match", 32'(mf[0]), 32'd1);
    for (int n = 2; n <= 66; n++) begin
      tick();
      if (n == 4)  check("a_byte0_last", 32'(bo[0]), 32'h69);
      if (n == 5)  check("a_byte1", 32'(bo[0]), 32'hc4);
      if (n == 61) begin
        check("a_byte15", 32'(bo[0]), 32'h5a);
        check("a_idx15", 32'(bi[0]), 32'd15);
      end
      if (n == 64) check("a_done_early", 32'(dn[0]), 32'd0);
      if (n == 65) begin
        check("a_done_pulse", 32'(dn[0]), 32'd1);
`ifdef AES_SEQ_AUTO_REPEAT_EN
        check("a_wrap_byte", 32'(bo[0]), 32'h69);
        check("a_wrap_idx", 32'(bi[0]), 32'd0);
`else
        check("a_done_byte", 32'(bo[0]), 32'h5a);
        check("a_done_valid", 32'(bv[0]), 32'd0);
`endif
      end
      if (n == 66) begin
        check("a_done_single", 32'(dn[0]), 32'd0);
`ifdef AES_SEQ_AUTO_REPEAT_EN
        check("a_wrap_hold", 32'(bo[0]), 32'h69);
`else
        check("a_done_keep", 32'(bo[0]), 32'h5a);
`endif
      end
    end

    // Mismatching block, then a second in_valid while presenting.
    blk[0] = BLK_B; exb[0] = 128'd0; vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    check("b_match", 32'(mf[0]), 32'd0);
    check("b_byte0", 32'(bo[0]), 32'h00);
    repeat (4) tick();
    check("b_byte1", 32'(bo[0]), 32'h11);
    blk[0] = BLK_A; exb[0] = BLK_A; vld[0] = 1'b1;
`ifdef AES_SEQ_AUTO_REPEAT_EN
    check("busy_ready", 32'(rdy[0]), 32'd1);
`else
    check("busy_ready", 32'(rdy[0]), 32'd0);
`endif
    tick();
    vld[0] = 1'b0;
`ifdef AES_SEQ_AUTO_REPEAT_EN
    check("restart_byte", 32'(bo[0]), 32'h69);
    check("restart_idx", 32'(bi[0]), 32'd0);
    check("restart_match", 32'(mf[0]), 32'd1);
`else
    check("busy_byte", 32'(bo[0]), 32'h11);
    check("busy_idx", 32'(bi[0]), 32'd1);
    check("busy_match", 32'(mf[0]), 32'd0);
`endif

    // Hold for 10 cycles on byte 3.
    cnt = 0;
    while (bi[0] != 4'd3 && cnt < 40) begin tick(); cnt++; end
    check("hold_reach_idx3", 32'(bi[0]), 32'd3);
    cnt = 1;
    hld[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bi[0] == 4'd3) cnt++;
    end
    hld[0] = 1'b0;
`ifdef AES_SEQ_AUTO_REPEAT_EN
    check("hold_byte", 32'(bo[0]), 32'hd8);
`else
    check("hold_byte", 32'(bo[0]), 32'h33);
`endif
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bi[0] == 4'd3) cnt++;
    end
    check("hold_visible_cycles", 32'(cnt), 32'd14);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      if (dn[0]) seen = 1'b1;
    end
    check("hold_done_seen", 32'(seen), 32'd1);

    // Dwell 1: one byte per clock.
    blk[1] = BLK_A; exb[1] = BLK_A; vld[1] = 1'b1;
    tick();
    vld[1] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("d1_byte%0d", k), 32'(bo[1]), 32'(aBytes[k]));
      check($sformatf("d1_idx%0d", k), 32'(bi[1]), 32'(k));
      tick();
    end
    check("d1_done", 32'(dn[1]), 32'd1);
`ifdef AES_SEQ_AUTO_REPEAT_EN
    check("d1_wrap_byte", 32'(bo[1]), 32'h69);
`else
    check("d1_done_valid", 32'(bv[1]), 32'd0);
`endif

    // Reset in the middle of presentation at byte 7.
    blk[1] = BLK_B; exb[1] = BLK_B; vld[1] = 1'b1;
    tick();
    vld[1] = 1'b0;
    repeat (7) tick();
    check("d1_mid_idx", 32'(bi[1]), 32'd7);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    check("midrst_valid", 32'(bv[1]), 32'd0);
    check("midrst_idx", 32'(bi[1]), 32'd0);
    check("midrst_byte", 32'(bo[1]), 32'h00);
    check("midrst_match", 32'(mf[1]), 32'd0);
    check("midrst_ready", 32'(rdy[1]), 32'd1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (dn[1]) cnt++;
    end
    check("midrst_no_done", 32'(cnt), 32'd0);

    @(negedge clk);
    started = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
